// File: rtl/cpu_defs_pkg.sv
// ============================================================================
// Module : cpu_defs (package)
// Brief  : Shared MD-unit opcodes, latency defaults and E-stage result select.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cpu_defs;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic [1:0] {
        E_SEL_ALU = 2'd0,
        E_SEL_HI  = 2'd1,
        E_SEL_LO  = 2'd2,
        E_SEL_PC8 = 2'd3
    } e_sel_e;

    // True for the multi-cycle ops that occupy the unit.
    function automatic logic is_md_calc(input logic [2:0] op);
        return (op >= MD_MULT) && (op <= MD_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_calc.sv
// ============================================================================
// Module : mdu_calc
// Brief  : Combinational mult/div datapath producing {hi,lo} and div-by-zero.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mdu_calc
    import cpu_defs::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] res,
    output logic        div_by_zero
);

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_bm_safe;
    logic [31:0] w_bu_safe;
    logic [31:0] w_qs_mag;
    logic [31:0] w_rs_mag;
    logic [31:0] w_qs;
    logic [31:0] w_rs;
    logic [31:0] w_qu;
    logic [31:0] w_ru;

    assign w_prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign w_prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide via magnitudes: 0x80000000 / -1 yields 0x80000000 with no overflow trap.
    assign w_a_mag   = a[31] ? (~a + 32'd1) : a;
    assign w_b_mag   = b[31] ? (~b + 32'd1) : b;
    assign w_bm_safe = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
    assign w_bu_safe = (b == 32'd0) ? 32'd1 : b;
    assign w_qs_mag  = w_a_mag / w_bm_safe;
    assign w_rs_mag  = w_a_mag % w_bm_safe;
    assign w_qs      = (a[31] ^ b[31]) ? (~w_qs_mag + 32'd1) : w_qs_mag;
    assign w_rs      = a[31] ? (~w_rs_mag + 32'd1) : w_rs_mag;
    assign w_qu      = a / w_bu_safe;
    assign w_ru      = a % w_bu_safe;

    always_comb begin
        res         = 64'd0;
        div_by_zero = 1'b0;
        case (op)
            MD_MULT:  res = w_prod_s;
            MD_MULTU: res = w_prod_u;
            MD_DIV: begin
                res         = {w_rs, w_qs};
                div_by_zero = (b == 32'd0);
            end
            MD_DIVU: begin
                res         = {w_ru, w_qu};
                div_by_zero = (b == 32'd0);
            end
            default: res = 64'd0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/e_mdu.sv
// ============================================================================
// Module : e_mdu
// Brief  : E-stage multi-cycle multiply/divide unit holding HI/LO.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module e_mdu
    import cpu_defs::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int c_max_cyc = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_cnt_w   = $clog2(c_max_cyc + 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_busy;
    logic [2:0]         r_op;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [63:0]        w_res;
    logic               w_dbz;
    logic               w_md_req;

    mdu_calc u_calc (
        .op          (r_op),
        .a           (r_a),
        .b           (r_b),
        .res         (w_res),
        .div_by_zero (w_dbz)
    );

    assign w_md_req = start && is_md_calc(MDop);
    assign md_stall = r_busy | w_md_req;
    assign busy     = r_busy;
    assign HI       = r_hi;
    assign LO       = r_lo;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_op   <= MD_NONE;
            r_a    <= 32'd0;
            r_b    <= 32'd0;
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
        end else if (r_busy) begin
            r_cnt <= r_cnt - c_cnt_w'(1);
            if (r_cnt == c_cnt_w'(1)) begin
                r_busy <= 1'b0;
                r_op   <= MD_NONE;
                if (!w_dbz) begin
                    r_hi <= w_res[63:32];
                    r_lo <= w_res[31:0];
                end
            end
        end else if (start) begin
            case (MDop)
                MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                    r_op   <= MDop;
                    r_a    <= A;
                    r_b    <= B;
                    r_busy <= 1'b1;
                    r_cnt  <= ((MDop == MD_MULT) || (MDop == MD_MULTU))
                              ? c_cnt_w'(MULT_CYCLES) : c_cnt_w'(DIV_CYCLES);
                end
                MD_MTHI: r_hi <= A;
                MD_MTLO: r_lo <= A;
                default: r_op <= r_op;
            endcase
        end
    end

`ifdef E_MDU_HAZARD_ASSERT
    // Enable where the hazard unit is present: it must never issue an MD op into a busy unit.
    a_no_start_while_busy: assert property (@(posedge clk) disable iff (reset)
        !(start && r_busy && (MDop >= MD_MULT) && (MDop <= MD_MTLO)))
        else $error("e_mdu: MD op issued while busy");
`endif

endmodule

`default_nettype wire

// File: tb/tb_e_mdu.sv
// ============================================================================
// Module : tb_e_mdu
// Brief  : Scoreboarded random/directed bench for e_mdu against a HI/LO model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_e_mdu;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  MDop;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        md_stall;
    logic [31:0] HI;
    logic [31:0] LO;

    e_mdu #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .MDop     (MDop),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .md_stall (md_stall),
        .HI       (HI),
        .LO       (LO)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural rules.
    function automatic exp_t ref_op(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b, input logic [31:0] hi,
                                    input logic [31:0] lo);
        exp_t           e;
        longint         sp;
        longint         sa;
        longint         sb_;
        longint unsigned up;
        e.hi = hi;
        e.lo = lo;
        e.lat = (op <= 3'd2) ? MULT_N : DIV_N;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        case (op)
            3'd1: begin
                sp = sa * sb_;
                e.hi = sp[63:32];
                e.lo = sp[31:0];
            end
            3'd2: begin
                up = longint'({32'd0, a}) * longint'({32'd0, b});
                e.hi = up[63:32];
                e.lo = up[31:0];
            end
            3'd3: if (b != 0) begin
                sp = sa / sb_;
                e.lo = sp[31:0];
                sp = sa % sb_;
                e.hi = sp[31:0];
            end
            3'd4: if (b != 0) begin
                e.lo = a / b;
                e.hi = a % b;
            end
            default: ;
        endcase
        return e;
    endfunction

    // Monitor: counts busy cycles and checks each completion against the scoreboard.
    initial begin
        logic prev_busy;
        int   bcnt;
        exp_t e;
        prev_busy = 1'b0;
        bcnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_busy = 1'b0;
                bcnt = 0;
            end else begin
                if (busy) begin
                    bcnt++;
                    chk("md_stall_busy", md_stall, 1);
                    chk("hi_hold_busy", HI, m_hi);
                    chk("lo_hold_busy", LO, m_lo);
                end else if (prev_busy) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("done_hi", HI, e.hi);
                        chk("done_lo", LO, e.lo);
                        chk("busy_len", bcnt, e.lat);
                    end
                    bcnt = 0;
                end
                prev_busy = busy;
            end
        end
    end

    task automatic do_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit intr);
        exp_t e;
        int   n;
        e = ref_op(op, a, b, m_hi, m_lo);
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b1; MDop = op; A = a; B = b;
        #1 chk("md_stall_start", md_stall, 1);
        @(posedge clk); #1;
        start = 1'b0; MDop = 3'($urandom); A = $urandom; B = $urandom;
        chk("busy_rise", busy, 1);
        n = 0;
        while (busy && n < 40) begin
            if (intr && n == 1) begin
                start = 1'b1; MDop = 3'd1; A = $urandom; B = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk("busy_timeout", busy, 0);
        m_hi = e.hi;
        m_lo = e.lo;
    endtask

    task automatic do_mt(input logic [2:0] op, input logic [31:0] a);
        @(posedge clk); #1;
        start = 1'b1; MDop = op; A = a; B = $urandom;
        #1;
        chk("mt_stall", md_stall, 0);
        chk(op == 3'd5 ? "mthi_old" : "mtlo_old", op == 3'd5 ? HI : LO, op == 3'd5 ? m_hi : m_lo);
        @(posedge clk); #1;
        start = 1'b0;
        if (op == 3'd5) m_hi = a; else m_lo = a;
        chk("mt_hi", HI, m_hi);
        chk("mt_lo", LO, m_lo);
        chk("mt_busy", busy, 0);
    endtask

    task automatic do_nop(input logic [2:0] op);
        @(posedge clk); #1;
        start = 1'b1; MDop = op; A = $urandom; B = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
        chk("nop_busy", busy, 0);
        chk("nop_hi", HI, m_hi);
        chk("nop_lo", LO, m_lo);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; MDop = 3'd0; A = 32'd0; B = 32'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_hi", HI, 0);
        chk("rst_lo", LO, 0);
        chk("rst_stall", md_stall, 0);

        do_md(3'd1, 32'hFFFF_FFFE, 32'd3, 0);
        chk("mult_hi", HI, 32'hFFFF_FFFF);
        chk("mult_lo", LO, 32'hFFFF_FFFA);
        do_md(3'd2, 32'hFFFF_FFFE, 32'd3, 0);
        chk("multu_hi", HI, 32'h0000_0002);
        do_md(3'd3, 32'hFFFF_FFF9, 32'd2, 0);
        chk("div_lo", LO, 32'hFFFF_FFFD);
        chk("div_hi", HI, 32'hFFFF_FFFF);
        do_md(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        chk("divovf_lo", LO, 32'h8000_0000);
        chk("divovf_hi", HI, 32'h0);
        do_mt(3'd5, 32'h1234);
        do_mt(3'd6, 32'h5678);
        do_md(3'd4, 32'd7, 32'd0, 0);
        chk("dbz_hi", HI, 32'h1234);
        chk("dbz_lo", LO, 32'h5678);
        do_md(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        chk("divu_lo", LO, 32'h7FFF_FFFC);
        chk("divu_hi", HI, 32'h1);
        do_mt(3'd6, 32'hDEAD_BEEF);
        @(posedge clk); #1 chk("mtlo_no_busy", busy, 0);
        do_md(3'd1, 32'd1000, 32'hFFFF_FFF6, 1);
        do_nop(3'd0);
        do_nop(3'd7);

        // Reset two cycles into a divide: no late write may follow.
        @(posedge clk); #1;
        start = 1'b1; MDop = 3'd3; A = 32'd100; B = 32'd7;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        #1;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_hi", HI, 0);
        chk("rstmid_lo", LO, 0);
        @(posedge clk); #1 reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (DIV_N + 3) begin
            @(posedge clk); #1;
            chk("rstmid_late", {busy, HI, LO}, 65'd0);
        end

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 3'($urandom_range(1, 6));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
            if (op <= 3'd4) do_md(op, a, b, 0);
            else            do_mt(op, a);
        end

        repeat (3) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- E-stage multiply/divide unit; sits beside the ALU, directly upstream of the EX/MEM pipeline register.
- Executes mult/multu/div/divu over multiple cycles and holds the HI/LO registers.
- Services mthi/mtlo writes and supplies HI/LO to the E-stage result mux for mfhi/mflo.
- Exports busy/stall information to the hazard unit.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high for mult/multu (>=1)
- DIV_CYCLES, 10, cycles busy stays high for div/divu (>=1)

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  E stage issues an MD op this cycle (instruction valid, not stalled, not flushed)
- MDop  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo
- A  in  32  forwarded rs value
- B  in  32  forwarded rt value
- busy  out  1  multi-cycle op in progress
- md_stall  out  1  combinational: busy | (start & MDop in 1..4); used by the hazard unit to stall any MD-class instruction in D
- HI  out  32  current HI register
- LO  out  32  current LO register

Behaviour:
- Reset (async, any time, including mid-operation): busy=0, HI=0, LO=0, counter=0, operand latches=0, pending op cleared. No result is written after reset releases.
- Idle accept: start=1, busy=0 and MDop in 1..4 at edge T:
  - latch A, B and MDop
  - load counter with MULT_CYCLES or DIV_CYCLES
  - busy=1 from cycle T+1
- Count: while busy, decrement the counter each edge. At the edge where counter==1:
  - write HI/LO
  - busy=0
  - the new HI/LO are visible from cycle T+N+1, where N is the latency
  - busy is high for exactly N cycles
- mthi/mtlo: start=1, busy=0, MDop=5/6 → HI<=A or LO<=A at that edge. Single cycle; busy stays 0.
- start while busy: ignored, with no effect on the counter, operands or HI/LO. The hazard unit guarantees this never occurs; an assertion checks it.
- MDop=0 or 7 with start=1: no-op.
- start=0: the MDop, A and B inputs are don't-care.
- mult: signed 32x32→64; HI=product[63:32], LO=product[31:0].
- multu: unsigned 32x32→64, same HI/LO split as mult.
- div:
  - signed; LO=quotient truncated toward zero; HI=remainder with the sign of the dividend
  - 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0
- divu: unsigned; LO=quotient, HI=remainder.
- Divide by zero (B==0 at accept): full DIV_CYCLES busy period; HI/LO unchanged at completion.
- Result computation: combinational from the latched operands. Computing at accept and delaying the write is also acceptable, provided the visible timing is identical.
- HI/LO outputs: registered, and change only at a completion edge, an mthi/mtlo edge, or reset.
- Same-cycle read: an mfhi/mflo in E in the cycle an mthi/mtlo is accepted sees the old value. D-stage stalling on md_stall prevents this case.

Decomposition:
- Shared package (cpu_defs):
  - MDop encodings MD_NONE..MD_MTLO
  - MULT_CYCLES/DIV_CYCLES defaults
  - the E-stage result-select code for HI/LO
- One sub-module: mdu_calc, purely combinational. Takes the latched op, A and B; produces 64-bit {hi,lo} and a div_by_zero flag.
- The counter, busy and HI/LO registers stay in e_mdu.

Test Plan:
- Reset mid-op: assert reset 2 cycles into a div; release → busy=0, HI=LO=0, no late write.
- mult: A=0xFFFFFFFE (-2), B=3, start at T → busy high T+1..T+5, busy low at T+6; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu: same operands → HI=0x00000002, LO=0xFFFFFFFA after 5 busy cycles.
- div:
  - A=0xFFFFFFF9 (-7), B=2 → busy for exactly 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF
  - A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0
- divu: A=7, B=0 after mthi 0x1234/mtlo 0x5678 → 10 busy cycles, HI=0x1234, LO=0x5678 unchanged. Also A=0xFFFFFFF9, B=2 → LO=0x7FFFFFFC, HI=1.
- mthi/mtlo and stall:
  - mtlo A=0xDEADBEEF → LO updates next cycle; busy never rises
  - start=1 with mult issued while busy → ignored, result of the first op only
  - md_stall=1 in the start cycle and in every busy cycle
